cordic_prerot: RTL and testbench

- Front end of the CORDIC rotation pipeline. Sits directly upstream of the first CordicStage (STG=0).
- Accepts (x, y, theta) over a valid/ready handshake and sign-extends x/y from IW to DW to add guard bits for CORDIC gain growth of about 1.647.
- Applies a ±90° quadrant pre-rotation so that the residual angle lies in [-pi/2, pi/2), inside the stage chain's convergence range of about ±99.9°.
- Registered output with a 2-entry skid buffer. The stage chain's en is driven from out_ready.

---
 rtl/cordic_pkg.sv | 19 +
 rtl/cordic_quad_map.sv | 62 ++++++
 rtl/cordic_prerot.sv | 125 ++++++++++++
 tb/tb_cordic_prerot.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cordic_pkg.sv
// Shared types, default widths and angle constants for the CORDIC rotation pipeline.
package cordic_pkg;

    localparam int unsigned CORDIC_DW = 12;
    localparam int unsigned CORDIC_AW = CORDIC_DW;
    localparam int unsigned CORDIC_IW = CORDIC_DW - 2;

    typedef enum logic [1:0] {
        QUAD_NONE = 2'd0,
        QUAD_P90  = 2'd1,
        QUAD_M90  = 2'd2
    } quad_e;

    // Quarter turn (+90 degrees) in Q1.(aw-1), where 1.0 represents pi.
    function automatic int unsigned angle_quarter(input int unsigned aw);
        return 32'd1 << (aw - 32'd2);
    endfunction

endpackage

// File: rtl/cordic_quad_map.sv
// Combinational quadrant decode and +/-90 degree x/y/angle pre-rotation.
// The quad_c port exists only when CORDIC_PREROT_QUAD_EN is defined.
module cordic_quad_map
    import cordic_pkg::*;
#(
    parameter int unsigned DW = CORDIC_DW,
    parameter int unsigned AW = CORDIC_AW,
    parameter int unsigned IW = CORDIC_IW
) (
    input  logic signed [IW-1:0] x_i,
    input  logic signed [IW-1:0] y_i,
    input  logic        [AW-1:0] a_i,
    output logic signed [DW-1:0] x_c,
    output logic signed [DW-1:0] y_c,
    output logic        [AW-1:0] a_c
`ifdef CORDIC_PREROT_QUAD_EN
    ,
    output quad_e                quad_c
`endif
);

    localparam logic [AW-1:0] QUARTER = AW'(angle_quarter(AW));

    logic signed [DW-1:0] xe;
    logic signed [DW-1:0] ye;
    logic        [1:0]    q;

    // Widen before negating so that -(-2^(IW-1)) is representable.
    assign xe = {{(DW-IW){x_i[IW-1]}}, x_i};
    assign ye = {{(DW-IW){y_i[IW-1]}}, y_i};
    assign q  = a_i[AW-1 -: 2];

    always_comb begin
        x_c = xe;
        y_c = ye;
        a_c = a_i;
        unique case (q)
            2'b01: begin
                x_c = -ye;
                y_c = xe;
                a_c = a_i - QUARTER;
            end
            2'b10: begin
                x_c = ye;
                y_c = -xe;
                a_c = a_i + QUARTER;
            end
            default: ;
        endcase
    end

`ifdef CORDIC_PREROT_QUAD_EN
    always_comb begin
        unique case (q)
            2'b01:   quad_c = QUAD_P90;
            2'b10:   quad_c = QUAD_M90;
            default: quad_c = QUAD_NONE;
        endcase
    end
`endif

endmodule

// File: rtl/cordic_prerot.sv
// CORDIC front end: input sign extension, quadrant pre-rotation, registered output with skid entry.
// Optional quad_out port enabled by CORDIC_PREROT_QUAD_EN.
module cordic_prerot
    import cordic_pkg::*;
#(
    parameter int unsigned DW = CORDIC_DW,
    parameter int unsigned AW = DW,
    parameter int unsigned IW = DW - 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic signed [IW-1:0] x_in,
    input  logic signed [IW-1:0] y_in,
    input  logic signed [AW-1:0] a_in,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic signed [DW-1:0] x_out,
    output logic signed [DW-1:0] y_out,
    output logic signed [AW-1:0] a_out
`ifdef CORDIC_PREROT_QUAD_EN
    ,
    output logic        [1:0]    quad_out
`endif
);

`ifdef CORDIC_PREROT_QUAD_EN
    localparam int unsigned PW = 2*DW + AW + 2;
`else
    localparam int unsigned PW = 2*DW + AW;
`endif

    logic signed [DW-1:0] x_map;
    logic signed [DW-1:0] y_map;
    logic        [AW-1:0] a_map;
    logic        [PW-1:0] beat_c;

    logic          out_valid_q, out_valid_d;
    logic [PW-1:0] out_q, out_d;
    logic          skid_valid_q, skid_valid_d;
    logic [PW-1:0] skid_q, skid_d;
    logic          in_ready_q, in_ready_d;
    logic          in_fire;

`ifdef CORDIC_PREROT_QUAD_EN
    quad_e quad_map;

    cordic_quad_map #(.DW(DW), .AW(AW), .IW(IW)) u_map (
        .x_i    (x_in),
        .y_i    (y_in),
        .a_i    (a_in),
        .x_c    (x_map),
        .y_c    (y_map),
        .a_c    (a_map),
        .quad_c (quad_map)
    );

    assign beat_c = {x_map, y_map, a_map, 2'(quad_map)};
`else
    cordic_quad_map #(.DW(DW), .AW(AW), .IW(IW)) u_map (
        .x_i (x_in),
        .y_i (y_in),
        .a_i (a_in),
        .x_c (x_map),
        .y_c (y_map),
        .a_c (a_map)
    );

    assign beat_c = {x_map, y_map, a_map};
`endif

    // Ready comes straight from a flop; reset only masks it, out_ready never reaches it.
    assign in_ready = in_ready_q & ~rst;
    assign in_fire  = in_valid & in_ready;

    // Output register refills from skid first, then from the input; otherwise skid catches the beat.
    always_comb begin
        out_valid_d  = out_valid_q;
        out_d        = out_q;
        skid_valid_d = skid_valid_q;
        skid_d       = skid_q;
        if (!out_valid_q || out_ready) begin
            if (skid_valid_q) begin
                out_valid_d  = 1'b1;
                out_d        = skid_q;
                skid_valid_d = 1'b0;
            end else if (in_fire) begin
                out_valid_d = 1'b1;
                out_d       = beat_c;
            end else begin
                out_valid_d = 1'b0;
            end
        end else if (in_fire) begin
            skid_valid_d = 1'b1;
            skid_d       = beat_c;
        end
        in_ready_d = ~skid_valid_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q  <= 1'b0;
            out_q        <= '0;
            skid_valid_q <= 1'b0;
            skid_q       <= '0;
            in_ready_q   <= 1'b1;
        end else begin
            out_valid_q  <= out_valid_d;
            out_q        <= out_d;
            skid_valid_q <= skid_valid_d;
            skid_q       <= skid_d;
            in_ready_q   <= in_ready_d;
        end
    end

    assign out_valid = out_valid_q;
    assign x_out     = out_q[PW-1 -: DW];
    assign y_out     = out_q[PW-DW-1 -: DW];
    assign a_out     = out_q[PW-2*DW-1 -: AW];
`ifdef CORDIC_PREROT_QUAD_EN
    assign quad_out  = out_q[1:0];
`endif

endmodule

// File: tb/tb_cordic_prerot.sv
// Self-checking bench for cordic_prerot: vector table, backpressure, reset-in-stall and random traffic.
module tb_cordic_prerot;

    localparam int unsigned DW = 12;
    localparam int unsigned AW = 12;
    localparam int unsigned IW = 10;

    typedef struct { int x; int y; int a; int q; } beat_t;
    typedef struct { int xi; int yi; int ai; int ex; int ey; int ea; int eq; } vec_t;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 in_valid;
    logic                 in_ready;
    logic signed [IW-1:0] x_in;
    logic signed [IW-1:0] y_in;
    logic        [AW-1:0] a_in;
    logic                 out_valid;
    logic                 out_ready;
    logic signed [DW-1:0] x_out;
    logic signed [DW-1:0] y_out;
    logic        [AW-1:0] a_out;
`ifdef CORDIC_PREROT_QUAD_EN
    logic        [1:0]    quad_out;
`endif

    beat_t sb[$];
    int    total = 0;
    int    bad   = 0;
    int    cyc   = 0;
    bit    rand_ready = 1'b0;
    bit    ready_cmd  = 1'b1;

    cordic_prerot #(.DW(DW), .AW(AW), .IW(IW)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x_in      (x_in),
        .y_in      (y_in),
        .a_in      (a_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .x_out     (x_out),
        .y_out     (y_out),
        .a_out     (a_out)
`ifdef CORDIC_PREROT_QUAD_EN
        ,
        .quad_out  (quad_out)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: rotate by a quarter turn toward zero when the angle is outside [-0.5, 0.5).
    function automatic beat_t model(input int xi, input int yi, input int ai);
        beat_t r;
        int    quarter = 1 << (AW - 2);
        int    full    = 1 << AW;
        if (ai >= quarter && ai < 2*quarter)
            r = '{-yi, xi, (ai - quarter + full) % full, 1};
        else if (ai >= 2*quarter && ai < 3*quarter)
            r = '{yi, -xi, (ai + quarter) % full, 2};
        else
            r = '{xi, yi, ai, 0};
        return r;
    endfunction

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic send(input int xi, input int yi, input int ai, input beat_t e);
        int n = 0;
        in_valid = 1'b1;
        x_in = IW'(xi);
        y_in = IW'(yi);
        a_in = AW'(ai);
        forever begin
            @(negedge clk);
            if (in_ready) begin
                sb.push_back(e);
                @(posedge clk);
                #1;
                in_valid = 1'b0;
                break;
            end
            @(posedge clk);
            #1;
            n++;
            if (n > 50) begin
                check("accept_timeout", 1, 0);
                in_valid = 1'b0;
                break;
            end
        end
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(posedge clk);
            n++;
        end
        #1;
        check("drain_left", sb.size(), 0);
    endtask

    initial begin
        vec_t  vt[10];
        beat_t e;
        int    start;

        vt[0] = '{100,    0, 'h100,  100,    0, 'h100, 0};
        vt[1] = '{100,    0, 'h500,    0,  100, 'h100, 1};
        vt[2] = '{100,    0, 'hA00,    0, -100, 'hE00, 2};
        vt[3] = '{5,   -512, 'h600,  512,    5, 'h200, 1};
        vt[4] = '{7,     -3, 'hC00,    7,   -3, 'hC00, 0};
        vt[5] = '{-20,   30, 'h3FF,  -20,   30, 'h3FF, 0};
        vt[6] = '{-512, 511, 'h400, -511, -512, 'h000, 1};
        vt[7] = '{-512,-512, 'h800, -512,  512, 'hC00, 2};
        vt[8] = '{1,      2, 'hBFF,    2,   -1, 'hFFF, 2};
        vt[9] = '{3,      4, 'h7FF,   -4,    3, 'h3FF, 1};

        rst = 1'b1; in_valid = 1'b0; x_in = '0; y_in = '0; a_in = '0; out_ready = 1'b1;

        fork
            forever @(posedge clk) cyc++;
            forever begin
                @(posedge clk);
                #2;
                out_ready = rand_ready ? 1'($urandom_range(0, 1)) : ready_cmd;
            end
            begin : monitor
                bit                      prev_stall = 1'b0;
                logic [2*DW+AW-1:0]      held = '0;
                beat_t                   m;
                forever begin
                    @(negedge clk);
                    if (rst) begin
                        prev_stall = 1'b0;
                    end else begin
                        if (prev_stall)
                            check("hold_stable", int'({x_out, y_out, a_out} != held), 0);
                        if (out_valid && out_ready) begin
                            if (sb.size() == 0) begin
                                check("unexpected_beat", 1, 0);
                            end else begin
                                m = sb.pop_front();
                                check("x_out", int'($signed(x_out)), m.x);
                                check("y_out", int'($signed(y_out)), m.y);
                                check("a_out", int'(a_out), m.a);
`ifdef CORDIC_PREROT_QUAD_EN
                                check("quad_out", int'(quad_out), m.q);
`endif
                            end
                        end
                        prev_stall = out_valid && !out_ready;
                        held = {x_out, y_out, a_out};
                    end
                end
            end
        join_none

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", int'(in_ready), 0);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_x_out", int'(x_out), 0);
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check("post_rst_in_ready", int'(in_ready), 1);
        @(posedge clk); #1;

        // Single-beat latency
        e = '{vt[0].ex, vt[0].ey, vt[0].ea, vt[0].eq};
        send(vt[0].xi, vt[0].yi, vt[0].ai, e);
        @(negedge clk);
        check("latency_out_valid", int'(out_valid), 1);
        @(posedge clk); #1;

        // Table at full throughput
        start = cyc;
        for (int i = 1; i < 10; i++) begin
            e = '{vt[i].ex, vt[i].ey, vt[i].ea, vt[i].eq};
            send(vt[i].xi, vt[i].yi, vt[i].ai, e);
        end
        check("throughput_cycles", cyc - start, 9);
        drain();

        // Backpressure: two accepted, third held off
        ready_cmd = 1'b0;
        send(1, 2, 'h010, '{1, 2, 'h010, 0});
        send(1, 2, 'h020, '{1, 2, 'h020, 0});
        @(negedge clk);
        check("bp_in_ready_low", int'(in_ready), 0);
        check("bp_out_valid", int'(out_valid), 1);
        check("bp_head_a", int'(a_out), 'h010);
        @(posedge clk); #1;
        in_valid = 1'b1; x_in = 10'sd1; y_in = 10'sd2; a_in = 12'h030;
        repeat (3) begin
            @(negedge clk);
            check("bp_hold_in_ready", int'(in_ready), 0);
            @(posedge clk); #1;
        end
        ready_cmd = 1'b1;
        send(1, 2, 'h030, '{1, 2, 'h030, 0});
        drain();

        // Reset while stalled with skid full
        ready_cmd = 1'b0;
        send(9, 9, 'h050, '{9, 9, 'h050, 0});
        send(8, 8, 'h060, '{8, 8, 'h060, 0});
        @(negedge clk);
        check("stall_full_in_ready", int'(in_ready), 0);
        @(posedge clk); #1;
        rst = 1'b1;
        sb.delete();
        @(negedge clk);
        check("mid_rst_in_ready", int'(in_ready), 0);
        @(posedge clk); #1 rst = 1'b0;
        ready_cmd = 1'b1;
        @(negedge clk);
        check("mid_rst_out_valid", int'(out_valid), 0);
        check("mid_rst_x", int'(x_out), 0);
        check("mid_rst_y", int'(y_out), 0);
        check("mid_rst_a", int'(a_out), 0);
        check("mid_rst_in_ready_after", int'(in_ready), 1);
        repeat (4) begin
            @(negedge clk);
            check("no_stale_beat", int'(out_valid), 0);
        end
        @(posedge clk); #1;
        e = '{vt[3].ex, vt[3].ey, vt[3].ea, vt[3].eq};
        send(vt[3].xi, vt[3].yi, vt[3].ai, e);
        drain();

        // Random traffic under random backpressure
        rand_ready = 1'b1;
        for (int i = 0; i < 60; i++) begin
            int xi = int'($urandom_range(0, 1023)) - 512;
            int yi = int'($urandom_range(0, 1023)) - 512;
            int ai = int'($urandom_range(0, 4095));
            send(xi, yi, ai, model(xi, yi, ai));
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk); #1;
            end
        end
        rand_ready = 1'b0;
        ready_cmd  = 1'b1;
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
